// File: rtl/down_timer_16b.sv
// One-shot down counter with an optional auto-reload mode enabled by the DOWN_TIMER_PERIODIC_EN macro.
// All outputs are registered, and expired rises N+1 clocks after a start with load N; there is no backpressure.
module down_timer_16b #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             abort,
  input  logic             ack,
  input  logic             periodic,
  output logic             busy,
  output logic [WIDTH-1:0] count,
  output logic             expired,
  output logic             tick
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] load_q;
  logic             periodic_q;
  logic             busy_q;
  logic             expired_q;
  logic             tick_q;
  logic             accept;

  // A start is taken in IDLE, or in EXPIRED together with ack for a zero-gap restart.
  assign accept = start && ((state_q == IDLE) || ((state_q == EXPIRED) && ack));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      count_q    <= '0;
      load_q     <= '0;
      periodic_q <= 1'b0;
      busy_q     <= 1'b0;
      expired_q  <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      if (accept) begin
        load_q     <= load_val;
        periodic_q <= periodic;
        count_q    <= load_val;
        if (load_val != '0) begin
          state_q   <= RUN;
          busy_q    <= 1'b1;
          expired_q <= 1'b0;
        end else begin
          state_q   <= EXPIRED;
          busy_q    <= 1'b0;
          expired_q <= 1'b1;
        end
      end else begin
        case (state_q)
          RUN: begin
            if (abort) begin
              state_q <= IDLE;
              count_q <= '0;
              busy_q  <= 1'b0;
            end else if (en && (count_q != '0)) begin
              if (count_q == WIDTH'(1)) begin
`ifdef DOWN_TIMER_PERIODIC_EN
                if (periodic_q) begin
                  count_q <= load_q;
                  tick_q  <= 1'b1;
                end else begin
                  state_q   <= EXPIRED;
                  count_q   <= '0;
                  busy_q    <= 1'b0;
                  expired_q <= 1'b1;
                end
`else
                state_q   <= EXPIRED;
                count_q   <= '0;
                busy_q    <= 1'b0;
                expired_q <= 1'b1;
`endif
              end else begin
                count_q <= count_q - WIDTH'(1);
              end
            end
          end
          EXPIRED: begin
            if (ack) begin
              state_q   <= IDLE;
              expired_q <= 1'b0;
              count_q   <= '0;
            end
          end
          IDLE: begin
            count_q <= '0;
          end
          default: begin
            state_q   <= IDLE;
            count_q   <= '0;
            busy_q    <= 1'b0;
            expired_q <= 1'b0;
          end
        endcase
      end
    end
  end

`ifndef DOWN_TIMER_PERIODIC_EN
  // One-shot build: the captured reload state has no consumer.
  logic cfg_unused;
  assign cfg_unused = ^{load_q, periodic_q};
`endif

  assign busy    = busy_q;
  assign count   = count_q;
  assign expired = expired_q;
  assign tick    = tick_q;

endmodule

// File: tb/tb_down_timer_16b.sv
// Directed bench for down_timer_16b; each scenario task checks its own hand-computed expectations.
module tb_down_timer_16b;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] load_val;
  logic        en;
  logic        abort;
  logic        ack;
  logic        periodic;
  logic        busy;
  logic [15:0] count;
  logic        expired;
  logic        tick;

  int total;
  int bad;

  down_timer_16b #(.WIDTH(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .load_val (load_val),
    .en       (en),
    .abort    (abort),
    .ack      (ack),
    .periodic (periodic),
    .busy     (busy),
    .count    (count),
    .expired  (expired),
    .tick     (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step();
    total++;
    if (count !== 16'h0000) begin bad++; $display("FAIL reset_count got=%h exp=0000", count); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++;
    if (expired !== 1'b0) begin bad++; $display("FAIL reset_expired got=%b exp=0", expired); end
    total++;
    if (tick !== 1'b0) begin bad++; $display("FAIL reset_tick got=%b exp=0", tick); end
    rst = 1'b0;
  endtask

  task automatic test_oneshot();
    logic [15:0] exp_cnt [4] = '{16'd3, 16'd2, 16'd1, 16'd0};
    logic        exp_bsy [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic        exp_xp  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    start = 1'b1; load_val = 16'd3; en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      start = 1'b0;
      total++;
      if (count !== exp_cnt[i] || busy !== exp_bsy[i] || expired !== exp_xp[i]) begin
        bad++;
        $display("FAIL oneshot_cyc%0d got cnt=%0d busy=%b exp=%b req cnt=%0d busy=%b exp=%b",
                 i, count, busy, expired, exp_cnt[i], exp_bsy[i], exp_xp[i]);
      end
    end
    step(); step();
    total++;
    if (expired !== 1'b1 || count !== 16'd0) begin
      bad++; $display("FAIL oneshot_hold got exp=%b cnt=%0d req exp=1 cnt=0", expired, count);
    end
    start = 1'b1; load_val = 16'd7; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    total++;
    if (expired !== 1'b1 || busy !== 1'b0 || count !== 16'd0) begin
      bad++; $display("FAIL expired_ignores_start_abort got exp=%b busy=%b cnt=%0d req 1 0 0", expired, busy, count);
    end
    ack = 1'b1;
    step();
    ack = 1'b0;
    total++;
    if (expired !== 1'b0 || busy !== 1'b0 || count !== 16'd0) begin
      bad++; $display("FAIL ack_to_idle got exp=%b busy=%b cnt=%0d req 0 0 0", expired, busy, count);
    end
  endtask

  task automatic test_enable();
    logic        en_seq  [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [15:0] exp_cnt [7] = '{16'd4, 16'd4, 16'd4, 16'd3, 16'd2, 16'd1, 16'd0};
    start = 1'b1; load_val = 16'd5; en = 1'b1;
    step();
    start = 1'b0;
    total++;
    if (count !== 16'd5 || busy !== 1'b1) begin
      bad++; $display("FAIL enable_load got cnt=%0d busy=%b req cnt=5 busy=1", count, busy);
    end
    for (int i = 0; i < 7; i++) begin
      en = en_seq[i];
      step();
      total++;
      if (count !== exp_cnt[i] || expired !== (i == 6)) begin
        bad++;
        $display("FAIL enable_cyc%0d got cnt=%0d exp=%b req cnt=%0d exp=%b", i, count, expired, exp_cnt[i], (i == 6));
      end
    end
    en = 1'b1; ack = 1'b1;
    step();
    ack = 1'b0;
  endtask

  task automatic test_abort();
    abort = 1'b1; ack = 1'b1;
    step();
    abort = 1'b0; ack = 1'b0;
    total++;
    if (busy !== 1'b0 || expired !== 1'b0 || count !== 16'd0) begin
      bad++; $display("FAIL idle_abort_ack got busy=%b exp=%b cnt=%0d req 0 0 0", busy, expired, count);
    end
    start = 1'b1; load_val = 16'h0002; en = 1'b1;
    step();
    start = 1'b0;
    step();
    total++;
    if (count !== 16'd1 || busy !== 1'b1) begin
      bad++; $display("FAIL abort_pre got cnt=%0d busy=%b req cnt=1 busy=1", count, busy);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    total++;
    if (count !== 16'd0 || busy !== 1'b0 || expired !== 1'b0) begin
      bad++; $display("FAIL abort_beats_tc got cnt=%0d busy=%b exp=%b req 0 0 0", count, busy, expired);
    end
    step();
    total++;
    if (expired !== 1'b0) begin bad++; $display("FAIL abort_no_expiry got exp=%b req 0", expired); end
    start = 1'b1; load_val = 16'd9;
    step();
    load_val = 16'd4;
    step();
    start = 1'b0;
    total++;
    if (count !== 16'd8 || busy !== 1'b1) begin
      bad++; $display("FAIL run_ignores_start got cnt=%0d busy=%b req cnt=8 busy=1", count, busy);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
  endtask

  task automatic test_back_to_back();
    start = 1'b1; load_val = 16'h0000; en = 1'b1;
    step();
    total++;
    if (expired !== 1'b1 || busy !== 1'b0 || count !== 16'd0) begin
      bad++; $display("FAIL zero_load got exp=%b busy=%b cnt=%0d req 1 0 0", expired, busy, count);
    end
    ack = 1'b1;
    step();
    total++;
    if (expired !== 1'b1 || busy !== 1'b0 || count !== 16'd0) begin
      bad++; $display("FAIL b2b_zero got exp=%b busy=%b cnt=%0d req 1 0 0", expired, busy, count);
    end
    load_val = 16'hFFFF;
    step();
    start = 1'b0; ack = 1'b0;
    total++;
    if (count !== 16'hFFFF || busy !== 1'b1 || expired !== 1'b0) begin
      bad++; $display("FAIL b2b_ffff got cnt=%h busy=%b exp=%b req ffff 1 0", count, busy, expired);
    end
    step();
    total++;
    if (count !== 16'hFFFE) begin bad++; $display("FAIL ffff_dec got cnt=%h req fffe", count); end
    abort = 1'b1;
    step();
    abort = 1'b0;
  endtask

  task automatic test_reset_midrun();
    start = 1'b1; load_val = 16'h1236; en = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    total++;
    if (count !== 16'h1234) begin bad++; $display("FAIL midrun_pre got cnt=%h req 1234", count); end
    #2 rst = 1'b1;
    #1;
    total++;
    if (count !== 16'h0000 || busy !== 1'b0 || expired !== 1'b0 || tick !== 1'b0) begin
      bad++; $display("FAIL async_reset got cnt=%h busy=%b exp=%b tick=%b req all 0", count, busy, expired, tick);
    end
    #2 rst = 1'b0;
    step(); step();
    total++;
    if (count !== 16'h0000 || busy !== 1'b0) begin
      bad++; $display("FAIL post_reset_idle got cnt=%h busy=%b req 0 0", count, busy);
    end
  endtask

`ifdef DOWN_TIMER_PERIODIC_EN
  task automatic test_periodic();
    logic [15:0] exp_cnt  [6] = '{16'd2, 16'd1, 16'd2, 16'd1, 16'd2, 16'd1};
    logic        exp_tick [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    start = 1'b1; load_val = 16'd2; periodic = 1'b1; en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      start = 1'b0; periodic = 1'b0;
      total++;
      if (count !== exp_cnt[i] || tick !== exp_tick[i] || expired !== 1'b0 || busy !== 1'b1) begin
        bad++;
        $display("FAIL periodic_cyc%0d got cnt=%0d tick=%b exp=%b busy=%b req cnt=%0d tick=%b exp=0 busy=1",
                 i, count, tick, expired, busy, exp_cnt[i], exp_tick[i]);
      end
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    total++;
    if (count !== 16'd0 || busy !== 1'b0 || tick !== 1'b0) begin
      bad++; $display("FAIL periodic_abort got cnt=%0d busy=%b tick=%b req 0 0 0", count, busy, tick);
    end
  endtask
`else
  task automatic test_periodic();
    logic [15:0] exp_cnt [3] = '{16'd2, 16'd1, 16'd0};
    start = 1'b1; load_val = 16'd2; periodic = 1'b1; en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      start = 1'b0; periodic = 1'b0;
      total++;
      if (count !== exp_cnt[i] || tick !== 1'b0 || expired !== (i == 2)) begin
        bad++;
        $display("FAIL oneshot_periodic_cyc%0d got cnt=%0d tick=%b exp=%b req cnt=%0d tick=0 exp=%b",
                 i, count, tick, expired, exp_cnt[i], (i == 2));
      end
    end
    ack = 1'b1;
    step();
    ack = 1'b0;
  endtask
`endif

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; start = 1'b0; load_val = '0; en = 1'b0;
    abort = 1'b0; ack = 1'b0; periodic = 1'b0;
    test_reset();
    test_oneshot();
    test_enable();
    test_abort();
    test_back_to_back();
    test_periodic();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
